// File: rtl/acia_pkg.sv
// acia_pkg: shared constants, enums and payload types for the ACIA responder.
//   Register-select addresses, STATUS/CTRL bit indices, TX/RX state encodings,
//   oversampling ratio and the received-byte payload struct.
package acia_pkg;

    localparam int unsigned DW         = 8;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned OS_W       = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W      = $clog2(DW);

    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DW - 1);

    localparam logic [1:0] RS_DATA   = 2'd0;
    localparam logic [1:0] RS_STATUS = 2'd1;
    localparam logic [1:0] RS_CTRL   = 2'd2;
    localparam logic [1:0] RS_DIV    = 2'd3;

    localparam int unsigned ST_RX_FULL  = 0;
    localparam int unsigned ST_TX_EMPTY = 1;
    localparam int unsigned ST_OVR      = 2;
    localparam int unsigned ST_FERR     = 3;
    localparam int unsigned ST_IRQ      = 7;

    localparam int unsigned CTRL_RX_IE = 0;
    localparam int unsigned CTRL_TX_IE = 1;
    localparam int unsigned CTRL_LOOP  = 2;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    typedef struct packed {
        logic          ferr;
        logic [DW-1:0] data;
    } acia_rx_byte_t;

endpackage

// File: rtl/acia_rx_core.sv
// acia_rx_core: 8N1 receiver with 2-flop synchroniser, start validation,
//   mid-bit sampling and a one-cycle delivery pulse.
// Ports: fst_clk/res_n clock and async reset; soft_rst_i drops any partial frame;
//   tick_i oversample tick; rxd_i serial line; valid_o 1-cycle strobe with rx_o
//   {ferr, data}.
module acia_rx_core
    import acia_pkg::*;
(
    input  logic          fst_clk,
    input  logic          res_n,
    input  logic          soft_rst_i,
    input  logic          tick_i,
    input  logic          rxd_i,
    output logic          valid_o,
    output acia_rx_byte_t rx_o
);

    logic [1:0]       sync_q;
    logic             rx_s;
    rx_state_e        state_q, state_d;
    logic [OS_W-1:0]  os_q, os_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [DW-1:0]    shift_q, shift_d;
    logic             valid_q, valid_d;
    acia_rx_byte_t    rx_q, rx_d;

    assign rx_s    = sync_q[1];
    assign valid_o = valid_q;
    assign rx_o    = rx_q;

    // Next-state: start checked at half a bit, then one sample per bit period.
    always_comb begin
        state_d = state_q;
        os_d    = os_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        valid_d = 1'b0;
        if (tick_i) begin
            case (state_q)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state_d = RX_START;
                        os_d    = '0;
                    end
                end
                RX_START: begin
                    if (os_q == OS_MID) begin
                        os_d    = '0;
                        bit_d   = '0;
                        state_d = rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        os_d = os_q + OS_W'(1);
                    end
                end
                RX_DATA: begin
                    if (os_q == OS_LAST) begin
                        os_d    = '0;
                        shift_d = {rx_s, shift_q[DW-1:1]};
                        bit_d   = bit_q + BIT_W'(1);
                        if (bit_q == BIT_LAST) state_d = RX_STOP;
                    end else begin
                        os_d = os_q + OS_W'(1);
                    end
                end
                RX_STOP: begin
                    if (os_q == OS_LAST) begin
                        os_d      = '0;
                        state_d   = RX_IDLE;
                        valid_d   = 1'b1;
                        rx_d.data = shift_q;
                        rx_d.ferr = ~rx_s;
                    end else begin
                        os_d = os_q + OS_W'(1);
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
        if (soft_rst_i) begin
            state_d = RX_IDLE;
            os_d    = '0;
            bit_d   = '0;
            valid_d = 1'b0;
        end
    end

    // State register; synchroniser resets to the idle (mark) level.
    always_ff @(posedge fst_clk or negedge res_n) begin
        if (!res_n) begin
            sync_q  <= '1;
            state_q <= RX_IDLE;
            os_q    <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            rx_q    <= '0;
        end else begin
            sync_q  <= {sync_q[0], rxd_i};
            state_q <= state_d;
            os_q    <= os_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            rx_q    <= rx_d;
        end
    end

endmodule

// File: rtl/acia_responder.sv
// acia_responder: phi2-qualified 6502 bus UART (8N1) with one TX and one RX byte
//   buffer, programmable baud tick and active-low interrupt.
// Ports: fst_clk/res_n clock and async active-low reset; phi2, rw_n, cs_n, rs,
//   data_in CPU bus; data_out combinational read data (0 when deselected);
//   irq_n registered interrupt; txd serial out; rxd serial in.
// Config: ACIA_LOOPBACK_EN enables CTRL bit2 internal TX->RX loop.
module acia_responder
    import acia_pkg::*;
#(
    parameter logic [DW-1:0] DIV_RST = 8'd26
) (
    input  logic          fst_clk,
    input  logic          res_n,
    input  logic          phi2,
    input  logic          rw_n,
    input  logic          cs_n,
    input  logic [1:0]    rs,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          irq_n,
    output logic          txd,
    input  logic          rxd
);

    logic             phi2_q;
    logic             commit_c, wr_c, rd_c, soft_rst_c, tick_c;
    logic [DW-1:0]    cnt_q, cnt_d, div_q, div_d;
    logic             rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d;
    logic             loop_q, loop_d;
    logic [DW-1:0]    tx_hold_q, tx_hold_d, rx_data_q, rx_data_d;
    logic             tx_empty_q, tx_empty_d, rx_full_q, rx_full_d;
    logic             ovr_q, ovr_d, ferr_q, ferr_d;
    tx_state_e        tx_state_q, tx_state_d;
    logic [OS_W-1:0]  tx_os_q, tx_os_d;
    logic [BIT_W-1:0] tx_bit_q, tx_bit_d;
    logic [DW-1:0]    tx_shift_q, tx_shift_d;
    logic             tx_line_q, tx_line_d, txd_q, txd_d, irq_n_q, irq_n_d;
    logic             rx_line_c, rx_valid;
    acia_rx_byte_t    rx_byte;
    logic [DW-1:0]    status_c;

    // One commit per phi2 cycle, on the sampled falling edge.
    assign commit_c   = phi2_q & ~phi2 & ~cs_n;
    assign wr_c       = commit_c & ~rw_n;
    assign rd_c       = commit_c & rw_n;
    assign soft_rst_c = wr_c & (rs == RS_STATUS);
    assign tick_c     = (cnt_q == div_q);

`ifdef ACIA_LOOPBACK_EN
    always_ff @(posedge fst_clk or negedge res_n) begin
        if (!res_n) loop_q <= 1'b0;
        else        loop_q <= loop_d;
    end
`else
    assign loop_q = 1'b0;
    assign loop_d = 1'b0;
`endif

    assign rx_line_c = loop_q ? tx_line_q : rxd;

    acia_rx_core u_rx (
        .fst_clk    (fst_clk),
        .res_n      (res_n),
        .soft_rst_i (soft_rst_c),
        .tick_i     (tick_c),
        .rxd_i      (rx_line_c),
        .valid_o    (rx_valid),
        .rx_o       (rx_byte)
    );

    // Bus side effects, RX delivery and TX FSM next-state.
    always_comb begin
        cnt_d      = tick_c ? '0 : cnt_q + DW'(1);
        div_d      = div_q;
        rx_ie_d    = rx_ie_q;
        tx_ie_d    = tx_ie_q;
`ifdef ACIA_LOOPBACK_EN
        loop_d     = loop_q;
`endif
        tx_hold_d  = tx_hold_q;
        tx_empty_d = tx_empty_q;
        rx_data_d  = rx_data_q;
        rx_full_d  = rx_full_q;
        ovr_d      = ovr_q;
        ferr_d     = ferr_q;
        tx_state_d = tx_state_q;
        tx_os_d    = tx_os_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;

        if (wr_c) begin
            case (rs)
                RS_DATA: begin
                    if (tx_empty_q) begin
                        tx_hold_d  = data_in;
                        tx_empty_d = 1'b0;
                    end
                end
                RS_CTRL: begin
                    rx_ie_d = data_in[CTRL_RX_IE];
                    tx_ie_d = data_in[CTRL_TX_IE];
`ifdef ACIA_LOOPBACK_EN
                    loop_d  = data_in[CTRL_LOOP];
`endif
                end
                RS_DIV: begin
                    div_d = data_in;
                    cnt_d = '0;
                end
                default: ;
            endcase
        end

        if (rd_c && (rs == RS_DATA)) rx_full_d = 1'b0;
        if (rd_c && (rs == RS_STATUS)) begin
            ovr_d  = 1'b0;
            ferr_d = 1'b0;
        end

        // A delivery coinciding with a DATA read refills the buffer cleanly.
        if (rx_valid) begin
            if (!rx_full_q || (rd_c && (rs == RS_DATA))) begin
                rx_data_d = rx_byte.data;
                rx_full_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
            if (rx_byte.ferr) ferr_d = 1'b1;
        end

        if (tick_c) begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (!tx_empty_q) begin
                        tx_shift_d = tx_hold_q;
                        tx_empty_d = 1'b1;
                        tx_os_d    = '0;
                        tx_state_d = TX_START;
                    end
                end
                TX_START: begin
                    if (tx_os_q == OS_LAST) begin
                        tx_os_d    = '0;
                        tx_bit_d   = '0;
                        tx_state_d = TX_DATA;
                    end else begin
                        tx_os_d = tx_os_q + OS_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_os_q == OS_LAST) begin
                        tx_os_d    = '0;
                        tx_shift_d = {1'b0, tx_shift_q[DW-1:1]};
                        tx_bit_d   = tx_bit_q + BIT_W'(1);
                        if (tx_bit_q == BIT_LAST) tx_state_d = TX_STOP;
                    end else begin
                        tx_os_d = tx_os_q + OS_W'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_os_q == OS_LAST) begin
                        tx_os_d = '0;
                        // Pending byte follows the stop bit with no idle gap.
                        if (!tx_empty_q) begin
                            tx_shift_d = tx_hold_q;
                            tx_empty_d = 1'b1;
                            tx_state_d = TX_START;
                        end else begin
                            tx_state_d = TX_IDLE;
                        end
                    end else begin
                        tx_os_d = tx_os_q + OS_W'(1);
                    end
                end
                default: tx_state_d = TX_IDLE;
            endcase
        end

        if (soft_rst_c) begin
            tx_state_d = TX_IDLE;
            tx_os_d    = '0;
            tx_bit_d   = '0;
            tx_empty_d = 1'b1;
            rx_full_d  = 1'b0;
            ovr_d      = 1'b0;
            ferr_d     = 1'b0;
        end

        case (tx_state_d)
            TX_START: tx_line_d = 1'b0;
            TX_DATA:  tx_line_d = tx_shift_d[0];
            default:  tx_line_d = 1'b1;
        endcase
        txd_d   = tx_line_d | loop_d;
        irq_n_d = ~((rx_ie_d & rx_full_d) | (tx_ie_d & tx_empty_d));
    end

    // Register file, tick counter and TX state.
    always_ff @(posedge fst_clk or negedge res_n) begin
        if (!res_n) begin
            phi2_q     <= 1'b0;
            cnt_q      <= '0;
            div_q      <= DIV_RST;
            rx_ie_q    <= 1'b0;
            tx_ie_q    <= 1'b0;
            tx_hold_q  <= '0;
            tx_empty_q <= 1'b1;
            rx_data_q  <= '0;
            rx_full_q  <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_os_q    <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
            txd_q      <= 1'b1;
            irq_n_q    <= 1'b1;
        end else begin
            phi2_q     <= phi2;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            rx_ie_q    <= rx_ie_d;
            tx_ie_q    <= tx_ie_d;
            tx_hold_q  <= tx_hold_d;
            tx_empty_q <= tx_empty_d;
            rx_data_q  <= rx_data_d;
            rx_full_q  <= rx_full_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            tx_state_q <= tx_state_d;
            tx_os_q    <= tx_os_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
            txd_q      <= txd_d;
            irq_n_q    <= irq_n_d;
        end
    end

    assign irq_n = irq_n_q;
    assign txd   = txd_q;

    // Read mux.
    always_comb begin
        status_c              = '0;
        status_c[ST_RX_FULL]  = rx_full_q;
        status_c[ST_TX_EMPTY] = tx_empty_q;
        status_c[ST_OVR]      = ovr_q;
        status_c[ST_FERR]     = ferr_q;
        status_c[ST_IRQ]      = ~irq_n_q;
        data_out              = '0;
        if (!cs_n) begin
            case (rs)
                RS_DATA:   data_out = rx_data_q;
                RS_STATUS: data_out = status_c;
                RS_CTRL:   data_out = {5'b0, loop_q, tx_ie_q, rx_ie_q};
                default:   data_out = div_q;
            endcase
        end
    end

endmodule

// File: tb/tb_acia_responder.sv
// tb_acia_responder: register-table vectors plus TX/RX scoreboarded sequences.
module tb_acia_responder;

    logic       fst_clk = 1'b0;
    logic       res_n, phi2, rw_n, cs_n, rxd;
    logic [1:0] rs;
    logic [7:0] data_in, data_out;
    logic       irq_n, txd;

    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    typedef struct {
        logic       rw;
        logic [1:0] a;
        logic [7:0] wd;
        logic [7:0] exp_rd;
        logic       exp_irq_n;
    } vec_t;

    acia_responder dut (
        .fst_clk  (fst_clk),
        .res_n    (res_n),
        .phi2     (phi2),
        .rw_n     (rw_n),
        .cs_n     (cs_n),
        .rs       (rs),
        .data_in  (data_in),
        .data_out (data_out),
        .irq_n    (irq_n),
        .txd      (txd),
        .rxd      (rxd)
    );

    always #5 fst_clk = ~fst_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Full phi2 cycle; read data captured before the committing edge.
    task automatic bus_acc(input logic rw, input logic [1:0] a, input logic [7:0] wd,
                           output logic [7:0] rd);
        @(negedge fst_clk);
        cs_n = 1'b0; rw_n = rw; rs = a; data_in = wd; phi2 = 1'b1;
        @(negedge fst_clk);
        rd = data_out; phi2 = 1'b0;
        @(negedge fst_clk);
        cs_n = 1'b1; rw_n = 1'b1;
    endtask

    // Combinational look at a register without a phi2 edge (no commit).
    task automatic peek(input logic [1:0] a, output logic [7:0] v);
        cs_n = 1'b0; rw_n = 1'b1; rs = a;
        #1 v = data_out;
        cs_n = 1'b1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = fr[i];
            repeat (16) @(negedge fst_clk);
        end
        rxd = 1'b1;
    endtask

    task automatic wait_irq(input string name);
        int n;
        n = 0;
        while (irq_n !== 1'b0 && n < 400) begin
            @(negedge fst_clk);
            n++;
        end
        chk(name, irq_n, 1'b0);
    endtask

    // TX scoreboard consumer: decode frames at mid-bit (16 clk/bit).
    initial begin : tx_mon
        logic [9:0] fr;
        logic [7:0] e;
        forever begin
            @(negedge txd);
            if (mon_en) begin
                for (int i = 0; i < 10; i++) begin
                    repeat (i == 0 ? 8 : 16) @(posedge fst_clk);
                    #1 fr[i] = txd;
                end
                if (tx_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL tx_unexpected_frame: got %0h expected none", fr);
                end else begin
                    e = tx_q.pop_front();
                    chk("tx_frame", {22'd0, fr}, {22'd0, 1'b1, e, 1'b0});
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : main
        vec_t       tbl[13];
        logic [7:0] r;
        int         lo;

        tbl[0]  = '{1'b1, 2'd1, 8'h00, 8'h02, 1'b1};
        tbl[1]  = '{1'b1, 2'd3, 8'h00, 8'h1A, 1'b1};
        tbl[2]  = '{1'b1, 2'd2, 8'h00, 8'h00, 1'b1};
        tbl[3]  = '{1'b1, 2'd0, 8'h00, 8'h00, 1'b1};
        tbl[4]  = '{1'b0, 2'd2, 8'h02, 8'h00, 1'b0};
        tbl[5]  = '{1'b1, 2'd2, 8'h00, 8'h02, 1'b0};
        tbl[6]  = '{1'b1, 2'd1, 8'h00, 8'h82, 1'b0};
        tbl[7]  = '{1'b0, 2'd2, 8'h07, 8'h00, 1'b0};
`ifdef ACIA_LOOPBACK_EN
        tbl[8]  = '{1'b1, 2'd2, 8'h00, 8'h07, 1'b0};
`else
        tbl[8]  = '{1'b1, 2'd2, 8'h00, 8'h03, 1'b0};
`endif
        tbl[9]  = '{1'b0, 2'd2, 8'h00, 8'h00, 1'b1};
        tbl[10] = '{1'b0, 2'd3, 8'h00, 8'h00, 1'b1};
        tbl[11] = '{1'b1, 2'd3, 8'h00, 8'h00, 1'b1};
        tbl[12] = '{1'b1, 2'd1, 8'h00, 8'h02, 1'b1};

        res_n = 1'b0; phi2 = 1'b0; rw_n = 1'b1; cs_n = 1'b1;
        rs = 2'd0; data_in = 8'h00; rxd = 1'b1;
        repeat (3) @(negedge fst_clk);
        res_n = 1'b1;
        @(negedge fst_clk);
        chk("rst_txd", txd, 1'b1);
        chk("rst_irq_n", irq_n, 1'b1);
        chk("rst_data_out_deselected", data_out, 8'h00);

        // Register table (ends with DIV=0, CTRL=0).
        for (int i = 0; i < 13; i++) begin
            bus_acc(tbl[i].rw, tbl[i].a, tbl[i].wd, r);
            if (tbl[i].rw) chk($sformatf("tbl%0d_rd", i), r, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_irq_n", i), irq_n, tbl[i].exp_irq_n);
        end

        // TX: A5 then 3C queued during the first frame.
        mon_en = 1'b1;
        tx_q.push_back(8'hA5);
        bus_acc(1'b0, 2'd0, 8'hA5, r);
        peek(2'd1, r);
        chk("tx_empty_clear", r, 8'h00);
        @(negedge fst_clk);
        peek(2'd1, r);
        chk("tx_empty_one_tick", r, 8'h02);
        chk("tx_start_bit", txd, 1'b0);
        repeat (20) @(negedge fst_clk);
        tx_q.push_back(8'h3C);
        bus_acc(1'b0, 2'd0, 8'h3C, r);
        for (int n = 0; n < 800 && tx_q.size() != 0; n++) @(negedge fst_clk);
        chk("tx_drain", tx_q.size(), 0);
        repeat (20) @(negedge fst_clk);
        mon_en = 1'b0;

        // RX single byte with rx_ie.
        bus_acc(1'b0, 2'd2, 8'h01, r);
        rx_q.push_back(8'h3C);
        send_rx(8'h3C, 1'b1);
        wait_irq("rx_irq");
        peek(2'd1, r);
        chk("rx_status", r, 8'h83);
        bus_acc(1'b1, 2'd0, 8'h00, r);
        chk("rx_data", r, rx_q.pop_front());
        chk("rx_irq_clear", irq_n, 1'b1);

        // Overrun: second byte discarded.
        rx_q.push_back(8'h11);
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        bus_acc(1'b1, 2'd1, 8'h00, r);
        chk("ovr_status", r, 8'h87);
        bus_acc(1'b1, 2'd1, 8'h00, r);
        chk("ovr_status_cleared", r, 8'h83);
        bus_acc(1'b1, 2'd0, 8'h00, r);
        chk("ovr_data", r, rx_q.pop_front());
        peek(2'd1, r);
        chk("ovr_after_read", r, 8'h02);

        // False start, then framing error.
        rxd = 1'b0;
        repeat (4) @(negedge fst_clk);
        rxd = 1'b1;
        repeat (60) @(negedge fst_clk);
        peek(2'd1, r);
        chk("false_start_status", r, 8'h02);
        chk("false_start_irq_n", irq_n, 1'b1);
        rx_q.push_back(8'h5E);
        send_rx(8'h5E, 1'b0);
        wait_irq("ferr_irq");
        bus_acc(1'b1, 2'd1, 8'h00, r);
        chk("ferr_status", r, 8'h8B);
        bus_acc(1'b1, 2'd0, 8'h00, r);
        chk("ferr_data", r, rx_q.pop_front());
        repeat (20) @(negedge fst_clk);
        peek(2'd1, r);
        chk("ferr_cleared", r, 8'h02);

        // Soft reset mid-TX and mid-RX.
        bus_acc(1'b0, 2'd0, 8'h00, r);
        rxd = 1'b0;
        repeat (40) @(negedge fst_clk);
        chk("srst_pre_txd", txd, 1'b0);
        bus_acc(1'b0, 2'd1, 8'h00, r);
        chk("srst_txd", txd, 1'b1);
        rxd = 1'b1;
        peek(2'd1, r);
        chk("srst_status", r, 8'h02);
        lo = 0;
        repeat (300) begin
            @(negedge fst_clk);
            if (txd !== 1'b1) lo++;
        end
        chk("srst_txd_idle_cycles", lo, 0);
        peek(2'd1, r);
        chk("srst_no_rx_byte", r, 8'h02);

`ifdef ACIA_LOOPBACK_EN
        // Internal loop: byte returns on RX, txd pin stays high.
        bus_acc(1'b0, 2'd2, 8'h05, r);
        rx_q.push_back(8'h5A);
        bus_acc(1'b0, 2'd0, 8'h5A, r);
        lo = 0;
        for (int n = 0; n < 600 && irq_n !== 1'b0; n++) begin
            @(negedge fst_clk);
            if (txd !== 1'b1) lo++;
        end
        chk("loop_irq", irq_n, 1'b0);
        chk("loop_txd_low_cycles", lo, 0);
        bus_acc(1'b1, 2'd0, 8'h00, r);
        chk("loop_data", r, rx_q.pop_front());
        bus_acc(1'b0, 2'd2, 8'h01, r);
`endif

        // Hard reset mid-TX.
        bus_acc(1'b0, 2'd0, 8'h00, r);
        repeat (30) @(negedge fst_clk);
        chk("hrst_pre_txd", txd, 1'b0);
        res_n = 1'b0;
        #1;
        chk("hrst_txd", txd, 1'b1);
        chk("hrst_irq_n", irq_n, 1'b1);
        repeat (3) @(negedge fst_clk);
        res_n = 1'b1;
        @(negedge fst_clk);
        peek(2'd1, r);
        chk("hrst_status", r, 8'h02);
        peek(2'd3, r);
        chk("hrst_div", r, 8'h1A);
        peek(2'd2, r);
        chk("hrst_ctrl", r, 8'h00);
        repeat (50) @(negedge fst_clk);
        chk("hrst_txd_idle", txd, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
